// File: rtl/pe_seq_ctrl.sv
// Job sequencer for a single 2-D convolution PE: buffers a filter and an activation tile,
// replays both into the PE, runs one PE pass per output row and streams the row results out.
module pe_seq_ctrl #(
   parameter int DATA_BITWIDTH = 16,
   parameter int kernel_size   = 3,
   parameter int act_size      = 5,
   parameter int TIMEOUT       = 255,
   parameter int CNT_BITWIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_start,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   input  logic                     w_valid,
   output logic                     w_ready,
   input  logic [DATA_BITWIDTH-1:0] w_data,
   input  logic                     a_valid,
   output logic                     a_ready,
   input  logic [DATA_BITWIDTH-1:0] a_data,
   output logic                     psum_valid,
   input  logic                     psum_ready,
   output logic [DATA_BITWIDTH-1:0] psum_data,
   output logic                     pe_load_en_wght,
   output logic                     pe_load_en_act,
   output logic                     pe_start,
   output logic [DATA_BITWIDTH-1:0] pe_filt_in,
   output logic [DATA_BITWIDTH-1:0] pe_act_in,
   input  logic [DATA_BITWIDTH-1:0] pe_out,
   input  logic                     pe_load_done,
   input  logic                     pe_compute_done
);

   localparam int KK       = kernel_size * kernel_size;
   localparam int AA       = act_size * act_size;
   localparam int OUT_ROWS = act_size - kernel_size + 1;
   localparam int WI       = (KK > 1) ? $clog2(KK) : 1;
   localparam int AI       = (AA > 1) ? $clog2(AA) : 1;

   localparam logic [CNT_BITWIDTH-1:0] CNT_ONE  = CNT_BITWIDTH'(1);
   localparam logic [CNT_BITWIDTH-1:0] KK_LAST  = CNT_BITWIDTH'(KK - 1);
   localparam logic [CNT_BITWIDTH-1:0] AA_LAST  = CNT_BITWIDTH'(AA - 1);
   localparam logic [CNT_BITWIDTH-1:0] ROWS_END = CNT_BITWIDTH'(OUT_ROWS);
   localparam logic [CNT_BITWIDTH-1:0] WD_LAST  = CNT_BITWIDTH'(TIMEOUT - 1);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FILL_W  = 4'd1;
   localparam logic [3:0] S_LOAD_W  = 4'd2;
   localparam logic [3:0] S_WAIT_LW = 4'd3;
   localparam logic [3:0] S_FILL_A  = 4'd4;
   localparam logic [3:0] S_LOAD_A  = 4'd5;
   localparam logic [3:0] S_WAIT_LA = 4'd6;
   localparam logic [3:0] S_START   = 4'd7;
   localparam logic [3:0] S_WAIT_CD = 4'd8;
   localparam logic [3:0] S_OUT     = 4'd9;
   localparam logic [3:0] S_GAP     = 4'd10;
   localparam logic [3:0] S_FLUSH   = 4'd11;
   localparam logic [3:0] S_DONE    = 4'd12;
   localparam logic [3:0] S_ERR     = 4'd13;

   logic [3:0]               state_q, state_d;
   logic [CNT_BITWIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_BITWIDTH-1:0]  row_q, row_d;
   logic [CNT_BITWIDTH-1:0]  wd_q, wd_d;
   logic [DATA_BITWIDTH-1:0] psum_q, psum_d;
   logic [DATA_BITWIDTH-1:0] filt_q, filt_d;
   logic [DATA_BITWIDTH-1:0] act_q, act_d;
   logic [DATA_BITWIDTH-1:0] wbuf [KK];
   logic [DATA_BITWIDTH-1:0] abuf [AA];
   logic                     w_fire, a_fire, wd_expired;

   assign w_fire     = w_valid & w_ready;
   assign a_fire     = a_valid & a_ready;
   assign wd_expired = (wd_q == WD_LAST);

   // NOTE: the buffers have no reset; each entry is rewritten by its fill phase before it is replayed.
   always_ff @(posedge clk) begin
      if (w_fire) wbuf[cnt_q[WI-1:0]] <= w_data;
      if (a_fire) abuf[cnt_q[AI-1:0]] <= a_data;
   end

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      wd_d    = wd_q;
      psum_d  = psum_q;
      filt_d  = filt_q;
      act_d   = act_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (cfg_start) begin
               state_d = S_FILL_W;
               cnt_d   = '0;
               row_d   = '0;
            end
         end
         S_FILL_W: begin
            if (w_fire) begin
               if (cnt_q == KK_LAST) begin
                  state_d = S_LOAD_W;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         S_LOAD_W: begin
            filt_d = wbuf[cnt_q[WI-1:0]];
            if (cnt_q == KK_LAST) begin
               state_d = S_WAIT_LW;
               cnt_d   = '0;
               wd_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WAIT_LW: begin
            if (pe_load_done) begin
               state_d = S_FILL_A;
               cnt_d   = '0;
            end else if (wd_expired) begin
               state_d = S_ERR;
            end else begin
               wd_d = wd_q + CNT_ONE;
            end
         end
         S_FILL_A: begin
            if (a_fire) begin
               if (cnt_q == AA_LAST) begin
                  state_d = S_LOAD_A;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         S_LOAD_A: begin
            act_d = abuf[cnt_q[AI-1:0]];
            if (cnt_q == AA_LAST) begin
               state_d = S_WAIT_LA;
               cnt_d   = '0;
               wd_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WAIT_LA: begin
            if (pe_load_done) begin
               state_d = S_START;
            end else if (wd_expired) begin
               state_d = S_ERR;
            end else begin
               wd_d = wd_q + CNT_ONE;
            end
         end
         S_START: begin
            state_d = S_WAIT_CD;
            wd_d    = '0;
         end
         S_WAIT_CD: begin
            if (pe_compute_done) begin
               state_d = S_OUT;
               psum_d  = pe_out;
            end else if (wd_expired) begin
               state_d = S_ERR;
            end else begin
               wd_d = wd_q + CNT_ONE;
            end
         end
         // No watchdog here: downstream backpressure may stall indefinitely.
         S_OUT: begin
            if (psum_ready) begin
               state_d = S_GAP;
               row_d   = row_q + CNT_ONE;
               wd_d    = '0;
            end
         end
         // The PE drops compute_done only in an idle cycle, so hold start low until it does.
         S_GAP: begin
            if (!pe_compute_done) begin
               state_d = (row_q == ROWS_END) ? S_FLUSH : S_START;
            end else if (wd_expired) begin
               state_d = S_ERR;
            end else begin
               wd_d = wd_q + CNT_ONE;
            end
         end
         S_FLUSH: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         wd_q    <= '0;
         psum_q  <= '0;
         filt_q  <= '0;
         act_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         wd_q    <= wd_d;
         psum_q  <= psum_d;
         filt_q  <= filt_d;
         act_q   <= act_d;
      end
   end

   assign busy            = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign done            = (state_q == S_DONE);
   assign err             = (state_q == S_ERR);
   assign w_ready         = (state_q == S_FILL_W);
   assign a_ready         = (state_q == S_FILL_A);
   assign psum_valid      = (state_q == S_OUT);
   assign psum_data       = psum_q;
   assign pe_load_en_wght = (state_q == S_LOAD_W) && (cnt_q == '0);
   assign pe_load_en_act  = (state_q == S_LOAD_A) && (cnt_q == '0);
   assign pe_start        = (state_q == S_START) || (state_q == S_FLUSH);
   assign pe_filt_in      = (state_q == S_LOAD_W) ? wbuf[cnt_q[WI-1:0]] : filt_q;
   assign pe_act_in       = (state_q == S_LOAD_A) ? abuf[cnt_q[AI-1:0]] : act_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: behavioural PE model plus a psum scoreboard fed as each job is driven.
module tb_pe_seq_ctrl;

   localparam int DW       = 16;
   localparam int K        = 3;
   localparam int A        = 5;
   localparam int KK       = K * K;
   localparam int AA       = A * A;
   localparam int OUT_ROWS = A - K + 1;
   localparam int TIMEOUT  = 255;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_start, busy, done, err;
   logic          w_valid, w_ready, a_valid, a_ready;
   logic [DW-1:0] w_data, a_data;
   logic          psum_valid, psum_ready;
   logic [DW-1:0] psum_data;
   logic          pe_load_en_wght, pe_load_en_act, pe_start;
   logic [DW-1:0] pe_filt_in, pe_act_in, pe_out;
   logic          pe_load_done, pe_compute_done;

   int tests = 0;
   int fails = 0;
   int wv [KK];
   int av [AA];
   int sb [$];

   always #5 clk = ~clk;

   pe_seq_ctrl #(
      .DATA_BITWIDTH(DW), .kernel_size(K), .act_size(A), .TIMEOUT(TIMEOUT), .CNT_BITWIDTH(8)
   ) dut (
      .clk(clk), .reset(rst_n), .cfg_start(cfg_start), .busy(busy), .done(done), .err(err),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
      .pe_load_en_wght(pe_load_en_wght), .pe_load_en_act(pe_load_en_act), .pe_start(pe_start),
      .pe_filt_in(pe_filt_in), .pe_act_in(pe_act_in), .pe_out(pe_out),
      .pe_load_done(pe_load_done), .pe_compute_done(pe_compute_done)
   );

   // Behavioural PE: counted loads after a 1-cycle enable, 3-cycle compute, done held 3 idle cycles.
   logic [DW-1:0] pe_w [KK];
   logic [DW-1:0] pe_a [AA];
   int  pe_wc, pe_ac, pe_row, pe_busy, pe_hold, flush_cnt;
   bit  pe_ldw, pe_lda, block_ld;
   logic [DW-1:0] pe_val;

   function automatic logic [DW-1:0] pe_psum(input int r);
      int s = 0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            s += int'(pe_w[i*K+j]) * int'(pe_a[(r+i)*A+j]);
      return DW'(s);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_wc <= 0; pe_ac <= 0; pe_row <= 0; pe_busy <= 0; pe_hold <= 0;
         pe_ldw <= 1'b0; pe_lda <= 1'b0; pe_val <= '0;
         pe_out <= '0; pe_load_done <= 1'b0; pe_compute_done <= 1'b0;
      end else begin
         pe_load_done <= 1'b0;
         if (pe_load_en_wght) begin
            pe_w[0] <= pe_filt_in; pe_wc <= 1; pe_ldw <= 1'b1;
         end else if (pe_ldw) begin
            pe_w[pe_wc] <= pe_filt_in;
            if (pe_wc == KK-1) begin pe_ldw <= 1'b0; pe_load_done <= !block_ld; end
            else pe_wc <= pe_wc + 1;
         end
         if (pe_load_en_act) begin
            pe_a[0] <= pe_act_in; pe_ac <= 1; pe_lda <= 1'b1;
         end else if (pe_lda) begin
            pe_a[pe_ac] <= pe_act_in;
            if (pe_ac == AA-1) begin pe_lda <= 1'b0; pe_load_done <= !block_ld; end
            else pe_ac <= pe_ac + 1;
         end
         if (pe_start) begin
            if (pe_row == OUT_ROWS) begin
               pe_row <= 0; flush_cnt <= flush_cnt + 1;
            end else begin
               pe_busy <= 3; pe_val <= pe_psum(pe_row); pe_row <= pe_row + 1;
            end
         end else if (pe_busy > 0) begin
            pe_busy <= pe_busy - 1;
            if (pe_busy == 1) begin pe_compute_done <= 1'b1; pe_out <= pe_val; pe_hold <= 2; end
         end else if (pe_compute_done) begin
            if (pe_hold > 0) pe_hold <= pe_hold - 1;
            else pe_compute_done <= 1'b0;
         end
      end
   end

   int start_cnt = 0, lew_cnt = 0, lea_cnt = 0, done_rise = 0;
   logic done_d = 1'b0;
   always @(posedge clk) begin
      if (pe_start) start_cnt <= start_cnt + 1;
      if (pe_load_en_wght) lew_cnt <= lew_cnt + 1;
      if (pe_load_en_act) lea_cnt <= lea_cnt + 1;
      if (done && !done_d) done_rise <= done_rise + 1;
      done_d <= done;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "bench time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_row(input int r);
      int s = 0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            s += wv[i*K+j] * av[(r+i)*A+j];
      return s & 32'hFFFF;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_strobes"}, {23'd0, busy, done, err, w_ready, a_ready, psum_valid,
                                pe_load_en_wght, pe_load_en_act, pe_start}, 32'd0);
      check({tag, "_psum_data"}, psum_data, 32'd0);
      check({tag, "_filt_in"}, pe_filt_in, 32'd0);
      check({tag, "_act_in"}, pe_act_in, 32'd0);
   endtask

   task automatic start_job();
      @(negedge clk); cfg_start = 1'b1;
      @(negedge clk); cfg_start = 1'b0;
      check("launch_busy", busy, 1);
      check("launch_err_clear", err, 0);
   endtask

   task automatic send_w(input bit tog);
      int t;
      for (int i = 0; i < KK; i++) begin
         if (tog) begin w_valid = 1'b0; @(negedge clk); end
         w_valid = 1'b1; w_data = DW'(wv[i]);
         t = 0;
         while (w_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
         if (t >= 300) begin check("w_ready_wait", 0, 1); w_valid = 1'b0; return; end
         @(negedge clk);
      end
      w_valid = 1'b0;
   endtask

   task automatic send_a(input bit tog, input bit poke);
      int t;
      for (int i = 0; i < AA; i++) begin
         if (tog) begin a_valid = 1'b0; @(negedge clk); end
         a_valid = 1'b1; a_data = DW'(av[i]);
         t = 0;
         while (a_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
         if (t >= 300) begin check("a_ready_wait", 0, 1); a_valid = 1'b0; return; end
         if (poke && i == 3) cfg_start = 1'b1;
         @(negedge clk);
         if (poke && i == 3) begin
            cfg_start = 1'b0;
            check("poke_still_busy", busy, 1);
            check("poke_no_refill", w_ready, 0);
         end
      end
      a_valid = 1'b0;
   endtask

   task automatic collect(input int stall_row, input bit cfg_last);
      int t, exp, s0;
      for (int r = 0; r < OUT_ROWS; r++) begin
         t = 0;
         while (psum_valid !== 1'b1 && t < 500) begin @(negedge clk); t++; end
         if (t >= 500) begin check("psum_wait", 0, 1); return; end
         if (sb.size() == 0) begin check("sb_empty", 1, 0); return; end
         exp = sb.pop_front();
         check("psum_row", psum_data, exp);
         if (r == stall_row) begin
            s0 = start_cnt;
            repeat (20) begin
               @(negedge clk);
               check("stall_psum_stable", psum_data, exp);
            end
            check("stall_valid_held", psum_valid, 1);
            check("stall_no_start", start_cnt, s0);
         end
         psum_ready = 1'b1;
         if (cfg_last && r == OUT_ROWS-1) cfg_start = 1'b1;
         @(negedge clk);
         psum_ready = 1'b0; cfg_start = 1'b0;
         check("valid_drops_after_accept", psum_valid, 0);
      end
   endtask

   task automatic run_job(input bit push_model, input bit tog, input bit poke,
                          input int stall_row, input bit cfg_last);
      int s0, w0, a0, d0, f0, t;
      s0 = start_cnt; w0 = lew_cnt; a0 = lea_cnt; d0 = done_rise; f0 = flush_cnt;
      if (push_model) for (int r = 0; r < OUT_ROWS; r++) sb.push_back(exp_row(r));
      start_job();
      send_w(tog);
      send_a(tog, poke);
      collect(stall_row, cfg_last);
      t = 0;
      while (done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      check("done_seen", done, 1);
      @(negedge clk);
      check("done_idle_busy", busy, 0);
      check("starts_incl_flush", start_cnt - s0, OUT_ROWS + 1);
      check("flush_seen", flush_cnt - f0, 1);
      check("load_en_wght_1cyc", lew_cnt - w0, 1);
      check("load_en_act_1cyc", lea_cnt - a0, 1);
      check("one_done_per_job", done_rise - d0, 1);
   endtask

   initial begin
      int t;
      rst_n = 1'b0; cfg_start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
      w_data = '0; a_data = '0; psum_ready = 1'b0; block_ld = 1'b0; flush_cnt = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // 1: reference data with hand-computed row sums
      for (int i = 0; i < KK; i++) wv[i] = i + 1;
      for (int i = 0; i < AA; i++) av[i] = i + 1;
      sb.push_back(411); sb.push_back(636); sb.push_back(861);
      run_job(1'b0, 1'b0, 1'b0, -1, 1'b0);

      // 2: upstream valid toggling every cycle
      for (int i = 0; i < KK; i++) wv[i] = int'($urandom_range(1, 15));
      for (int i = 0; i < AA; i++) av[i] = int'($urandom_range(1, 15));
      run_job(1'b1, 1'b1, 1'b0, -1, 1'b0);
      for (int i = 0; i < KK; i++) check("pe_wbuf_word", pe_w[i], wv[i]);

      // 3: downstream stall on row 1
      for (int i = 0; i < AA; i++) av[i] = int'($urandom_range(1, 15));
      run_job(1'b1, 1'b0, 1'b0, 1, 1'b0);

      // 4: PE never reports load_done -> watchdog error, then a clean rerun
      block_ld = 1'b1;
      start_job();
      send_w(1'b0);
      t = 0;
      while (err !== 1'b1 && t < 400) begin
         @(negedge clk); t++;
         if (t == 200) check("err_not_early", err, 0);
      end
      check("err_cycle", t, KK + TIMEOUT);
      check("err_idle_busy", busy, 0);
      check("err_strobes", {29'd0, pe_start, pe_load_en_wght, pe_load_en_act}, 0);
      block_ld = 1'b0;
      run_job(1'b1, 1'b0, 1'b0, -1, 1'b0);

      // 5: asynchronous reset while waiting on compute_done
      for (int i = 0; i < KK; i++) wv[i] = int'($urandom_range(1, 15));
      start_job();
      send_w(1'b0);
      send_a(1'b0, 1'b0);
      t = 0;
      while (pe_start !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      check("first_start_seen", pe_start, 1);
      @(negedge clk);
      check("in_wait_cd_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_job(1'b1, 1'b0, 1'b0, -1, 1'b0);

      // 6: cfg_start during FILL_A and on the final accept are both dropped
      for (int i = 0; i < AA; i++) av[i] = int'($urandom_range(1, 15));
      run_job(1'b1, 1'b0, 1'b1, -1, 1'b1);
      repeat (5) @(negedge clk);
      check("final_cfg_dropped_done", done, 1);
      check("final_cfg_dropped_ready", w_ready, 0);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
